gmem_rd_arbiter: RTL and testbench

Round-robin arbiter that lets two read requesters share the single AXI4 read channel of `global_mem`, for example the instruction fetch path and the data load path of `fcpu`. The arbiter keeps one burst outstanding at a time. It holds the grant from the AR handshake until the R beat that carries `rlast`. It routes read data back only to the granted requester and checks burst length against `arlen`.

---
 rtl/fcpu_pkg.sv | 20 ++
 rtl/gmem_rd_arbiter.sv | 165 ++++++++++++++++
 tb/tb_gmem_rd_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fcpu_pkg
// Brief    : Shared types and width defaults for the fcpu global-memory path.
// Revision : 1.0 - initial release
// ============================================================================
package fcpu_pkg;

    localparam int GMEM_ADDR_W = 28;
    localparam int GMEM_DATA_W = 32;
    localparam int GMEM_ID_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } gmem_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/gmem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gmem_rd_arbiter
// Brief    : Two-requester round-robin arbiter for the global_mem AXI4 read
//            channel, one burst outstanding, with burst-length checking.
// Revision : 1.0 - initial release
// ============================================================================
module gmem_rd_arbiter
    import fcpu_pkg::*;
#(
    parameter int ADDR_W = GMEM_ADDR_W,
    parameter int DATA_W = GMEM_DATA_W,
    parameter int ID_W   = GMEM_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [ID_W-1:0]   m0_rid,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ID_W-1:0]   m1_rid,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [7:0]        s_arlen,
    output logic [ID_W-1:0]   s_arid,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [ID_W-1:0]   s_rid,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic              len_err
);

    gmem_arb_state_t state;
    gmem_arb_state_t state_nxt;

    logic       grant;
    logic       prio;
    logic [7:0] beats;
    logic       req_any;
    logic       grant_pick;
    logic       ar_hs;
    logic       r_hs;

    assign req_any    = m0_arvalid | m1_arvalid;
    // m1 wins when it is the only requester or when it holds the tie priority
    assign grant_pick = m1_arvalid & (~m0_arvalid | prio);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ar_hs      = 1'b0;
        r_hs       = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_rid     = '0;
        m1_rid     = '0;
        m0_rlast   = 1'b0;
        m1_rlast   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    ar_hs      = 1'b1;
                    m0_arready = ~grant;
                    m1_arready = grant;
                    state_nxt  = DATA;
                end
            end
            DATA: begin
                s_rready = grant ? m1_rready : m0_rready;
                if (grant) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rid    = s_rid;
                    m1_rlast  = s_rlast;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rid    = s_rid;
                    m0_rlast  = s_rlast;
                end
                r_hs = s_rvalid & s_rready;
                if (r_hs && s_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= 1'b0;
            prio     <= 1'b0;
            beats    <= 8'd0;
            len_err  <= 1'b0;
            s_araddr <= '0;
            s_arlen  <= 8'd0;
            s_arid   <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                grant    <= grant_pick;
                s_araddr <= grant_pick ? m1_araddr : m0_araddr;
                s_arlen  <= grant_pick ? m1_arlen  : m0_arlen;
                s_arid   <= grant_pick ? m1_arid   : m0_arid;
            end
            if (ar_hs) begin
                beats <= s_arlen;
            end
            // beats holds the number of beats still expected after the current one
            if (r_hs) begin
                if (s_rlast) begin
                    prio <= ~grant;
                    if (beats != 8'd0) begin
                        len_err <= 1'b1;
                    end
                end else begin
                    beats <= beats - 8'd1;
                    if (beats == 8'd0) begin
                        len_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmem_rd_arbiter
// Brief    : Self-checking bench for gmem_rd_arbiter against a burst-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gmem_rd_arbiter;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int IW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0][AW-1:0] m_araddr;
    logic [1:0][7:0]    m_arlen;
    logic [1:0][IW-1:0] m_arid;
    logic [1:0]         m_arvalid;
    logic [1:0]         m_rready;
    wire  [1:0]         m_arready;
    wire  [1:0]         m_rvalid;
    wire  [1:0]         m_rlast;
    wire  [1:0][DW-1:0] m_rdata;
    wire  [1:0][IW-1:0] m_rid;

    wire  [AW-1:0] s_araddr;
    wire  [7:0]    s_arlen;
    wire  [IW-1:0] s_arid;
    wire           s_arvalid;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [IW-1:0] s_rid;
    logic          s_rlast;
    logic          s_rvalid;
    wire           s_rready;
    wire           len_err;

    gmem_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]), .m0_arid(m_arid[0]),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_rdata(m_rdata[0]), .m0_rid(m_rid[0]), .m0_rlast(m_rlast[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
        .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]), .m1_arid(m_arid[1]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_rdata(m_rdata[1]), .m1_rid(m_rid[1]), .m1_rlast(m_rlast[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // stimulus knobs (main only)
    int ar_pct = 100, rv_pct = 100, rr_pct = 100, pres_pct = 100;
    bit garbage = 1'b0;
    req_t rq [2][512];
    int   rq_tail [2];
    int   ovr_v [64];
    int   ovr_tail = 0;

    // driver-owned bookkeeping
    int   rq_head [2];
    int   ovr_head = 0;
    bit   req_active [2];
    int   wait_cnt [2];
    int   last_wait [2];
    int   beats_seen [2];
    logic [IW-1:0] last_rid [2];
    int   order_log [1024];
    int   order_n = 0;
    bit   slv_active = 1'b0;
    int   slv_total, slv_idx;
    logic [IW-1:0] slv_id;

    // burst-level reference model
    int            md_owner;
    bit            md_pend, md_prio, md_err;
    int            md_got, md_blen;
    logic [AW-1:0] md_addr;
    logic [7:0]    md_len;
    logic [IW-1:0] md_id;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic mdl_reset();
        md_owner = -1; md_pend = 0; md_prio = 0; md_err = 0;
        md_got = 0; md_blen = 0; md_addr = '0; md_len = '0; md_id = '0;
    endtask

    task automatic mdl_step();
        if (md_owner < 0) begin
            if (m_arvalid != 2'b00) begin
                md_owner = (m_arvalid == 2'b11) ? int'(md_prio) : (m_arvalid[1] ? 1 : 0);
                md_pend  = 1;
                md_addr  = m_araddr[md_owner];
                md_len   = m_arlen[md_owner];
                md_id    = m_arid[md_owner];
            end
        end else if (md_pend) begin
            if (s_arready) begin
                md_pend = 0;
                md_blen = int'(md_len);
                md_got  = 0;
            end
        end else if (s_rvalid && m_rready[md_owner]) begin
            if (s_rlast ? (md_got != md_blen) : (md_got == md_blen)) md_err = 1;
            md_got++;
            if (s_rlast) begin
                md_prio  = (md_owner == 0);
                md_owner = -1;
            end
        end
    endtask

    initial begin : cmp
        bit arv, ind, mine;
        mdl_reset();
        forever begin
            @(negedge clk);
            if (rst) mdl_reset();
            arv = (md_owner >= 0) && md_pend;
            ind = (md_owner >= 0) && !md_pend;
            chk("s_arvalid", s_arvalid, arv);
            chk("s_araddr", s_araddr, md_addr);
            chk("s_arlen", s_arlen, md_len);
            chk("s_arid", s_arid, md_id);
            chk("s_rready", s_rready, ind ? m_rready[md_owner] : 1'b0);
            chk("len_err", len_err, md_err);
            for (int x = 0; x < 2; x++) begin
                mine = ind && (md_owner == x);
                chk($sformatf("m%0d_arready", x), m_arready[x], arv && s_arready && (md_owner == x));
                chk($sformatf("m%0d_rvalid", x), m_rvalid[x], mine && s_rvalid);
                chk($sformatf("m%0d_rdata", x), m_rdata[x], mine ? s_rdata : '0);
                chk($sformatf("m%0d_rid", x), m_rid[x], mine ? s_rid : '0);
                chk($sformatf("m%0d_rlast", x), m_rlast[x], mine && s_rlast);
            end
            @(posedge clk);
            if (rst) mdl_reset();
            else     mdl_step();
        end
    end

    initial begin : drv
        bit acc [2];
        bit ar_hs_s, r_hs_s;
        logic [7:0] arlen_s;
        logic [IW-1:0] arid_s;
        for (int x = 0; x < 2; x++) begin
            rq_head[x] = 0; req_active[x] = 0; wait_cnt[x] = 0;
            last_wait[x] = -1; beats_seen[x] = 0; last_rid[x] = '0;
        end
        m_araddr = '0; m_arlen = '0; m_arid = '0; m_arvalid = '0; m_rready = '0;
        s_arready = 0; s_rdata = '0; s_rid = '0; s_rlast = 0; s_rvalid = 0;
        forever begin
            @(negedge clk);
            for (int x = 0; x < 2; x++) begin
                acc[x] = m_arvalid[x] && m_arready[x];
                if (req_active[x]) begin
                    if (acc[x]) last_wait[x] = wait_cnt[x];
                    else        wait_cnt[x]++;
                end
                if (m_rvalid[x] && m_rready[x]) begin
                    beats_seen[x]++;
                    last_rid[x] = m_rid[x];
                end
            end
            ar_hs_s = s_arvalid && s_arready;
            arlen_s = s_arlen;
            arid_s  = s_arid;
            if (ar_hs_s) begin
                order_log[order_n] = m_arready[1] ? 1 : 0;
                order_n++;
            end
            r_hs_s = s_rvalid && s_rready;
            @(posedge clk);
            #1;
            if (rst) begin
                for (int x = 0; x < 2; x++) req_active[x] = 0;
                m_arvalid = '0; slv_active = 0; s_rvalid = 0; s_arready = 0;
            end else begin
                for (int x = 0; x < 2; x++) begin
                    if (acc[x]) begin
                        req_active[x] = 0;
                        m_arvalid[x] = 0;
                    end
                    if (!req_active[x] && rq_head[x] != rq_tail[x] && roll(pres_pct)) begin
                        m_araddr[x] = rq[x][rq_head[x]].addr;
                        m_arlen[x]  = rq[x][rq_head[x]].len;
                        m_arid[x]   = rq[x][rq_head[x]].id;
                        m_arvalid[x] = 1;
                        rq_head[x]++;
                        req_active[x] = 1;
                        wait_cnt[x] = 0;
                    end
                    m_rready[x] = roll(rr_pct);
                end
                if (ar_hs_s) begin
                    slv_active = 1;
                    slv_idx = 0;
                    slv_id = arid_s;
                    if (ovr_head != ovr_tail) begin
                        slv_total = ovr_v[ovr_head];
                        ovr_head++;
                    end else begin
                        slv_total = int'(arlen_s) + 1;
                    end
                end
                if (r_hs_s && slv_active) begin
                    slv_idx++;
                    if (slv_idx == slv_total) slv_active = 0;
                end
                if (!(slv_active && s_rvalid && !r_hs_s && !ar_hs_s)) begin
                    s_rdata = $urandom;
                    if (slv_active) begin
                        s_rvalid = roll(rv_pct);
                        s_rid    = slv_id;
                        s_rlast  = (slv_idx == slv_total - 1);
                    end else begin
                        s_rvalid = garbage && ($urandom_range(0, 3) == 0);
                        s_rid    = IW'($urandom);
                        s_rlast  = 1'($urandom);
                    end
                end
                s_arready = roll(ar_pct);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int x, input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id);
        rq[x][rq_tail[x]] = '{addr: a, len: l, id: id};
        rq_tail[x]++;
    endtask

    function automatic bit idle_now();
        return rq_head[0] == rq_tail[0] && rq_head[1] == rq_tail[1] &&
               !req_active[0] && !req_active[1] && !slv_active && md_owner < 0;
    endfunction

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (!idle_now() && n < budget) begin
            cyc(1);
            n++;
        end
        chk({nm, "_drained"}, idle_now(), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1;
        cyc(2);
        rst = 0;
    endtask

    initial begin : main
        int b0, b1, o, n, x;
        logic [7:0] l;
        rq_tail[0] = 0;
        rq_tail[1] = 0;
        cyc(3);

        // reset values, then a single 4-beat burst for m0
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_m_rvalid", m_rvalid, 2'b00);
        chk("rst_s_rready", s_rready, 1'b0);
        rst = 0;
        b0 = beats_seen[0]; b1 = beats_seen[1];
        push(0, 28'h0000100, 8'd3, 4'h1);
        drain("t1", 200);
        chk("t1_m0_beats", beats_seen[0] - b0, 4);
        chk("t1_m1_beats", beats_seen[1] - b1, 0);
        chk("t1_ar_latency", last_wait[0], 1);
        chk("t1_model_prio", md_prio, 1'b1);

        // simultaneous requests with prio=0: order 0,1,0
        do_reset();
        o = order_n;
        push(0, 28'h0000200, 8'd1, 4'h1);
        push(1, 28'h0000300, 8'd2, 4'h2);
        push(0, 28'h0000210, 8'd0, 4'h3);
        drain("t2", 300);
        chk("t2_order0", order_log[o], 0);
        chk("t2_order1", order_log[o + 1], 1);
        chk("t2_order2", order_log[o + 2], 0);
        chk("t2_m1_rid", last_rid[1], 4'h2);

        // AR backpressure, then toggling rready
        ar_pct = 0;
        o = order_n; b1 = beats_seen[1];
        push(1, 28'h0004440, 8'd4, 4'h5);
        cyc(7);
        chk("t3_arvalid_held", s_arvalid, 1'b1);
        chk("t3_addr_held", s_araddr, 28'h0004440);
        chk("t3_no_arready", m_arready, 2'b00);
        chk("t3_no_grant", order_n - o, 0);
        ar_pct = 100; rr_pct = 50;
        drain("t3", 300);
        chk("t3_m1_beats", beats_seen[1] - b1, 5);
        rr_pct = 100;

        // short burst sets sticky len_err
        do_reset();
        ovr_v[ovr_tail] = 1; ovr_tail++;
        push(0, 28'h0000500, 8'd1, 4'h7);
        drain("t4a", 200);
        chk("t4_len_err", len_err, 1'b1);
        push(1, 28'h0000600, 8'd2, 4'h8);
        drain("t4b", 200);
        chk("t4_len_err_sticky", len_err, 1'b1);
        chk("t4_model_err", md_err, 1'b1);

        // 256-beat burst
        do_reset();
        b0 = beats_seen[0];
        rv_pct = 80;
        push(0, 28'h0007000, 8'd255, 4'h9);
        drain("t5", 2000);
        chk("t5_m0_beats", beats_seen[0] - b0, 256);
        chk("t5_model_beats", md_got, 256);
        chk("t5_len_err", len_err, 1'b0);
        rv_pct = 100;

        // asynchronous reset in the middle of a burst
        do_reset();
        b0 = beats_seen[0];
        push(0, 28'h0000800, 8'd3, 4'h4);
        n = 0;
        while (beats_seen[0] - b0 < 2 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("t6_beats_before_rst", beats_seen[0] - b0, 2);
        #1;
        rst = 1;
        #1;
        chk("t6_async_s_rready", s_rready, 1'b0);
        chk("t6_async_m_rvalid", m_rvalid, 2'b00);
        chk("t6_async_s_arvalid", s_arvalid, 1'b0);
        cyc(2);
        rst = 0;
        b1 = beats_seen[1];
        push(1, 28'h0000900, 8'd2, 4'h6);
        drain("t6", 200);
        chk("t6_m1_beats", beats_seen[1] - b1, 3);
        chk("t6_len_err", len_err, 1'b0);

        // randomized traffic with stray R beats outside DATA
        do_reset();
        garbage = 1; ar_pct = 60; rv_pct = 70; rr_pct = 70; pres_pct = 40;
        o = order_n;
        for (int i = 0; i < 120; i++) begin
            x = int'($urandom_range(0, 1));
            l = ($urandom_range(0, 39) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
            push(x, AW'($urandom), l, IW'($urandom));
        end
        drain("t7", 30000);
        chk("t7_bursts", order_n - o, 120);
        chk("t7_len_err", len_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
